// File: rtl/hzd_scoreboard.sv
// Scoreboard hazard unit for the ID stage: per-register countdowns drive stall/bubble.
// Optional stall-cycle performance counter enabled with `define HZD_PERF_EN.
module hzd_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_branch,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              mem_wait,
    input  logic              ex_kill,
    output logic              stall,
    output logic              pc_write,
    output logic              bubble,
    output logic [31:0]       stall_cycles
);

    localparam logic [CNT_W-1:0] ALU_C  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0]  cnt   [NUM_REGS];
    logic [CNT_W-1:0]  cnt_n [NUM_REGS];
    logic              u_vld, u_vld_n;
    logic [REG_AW-1:0] u_rd, u_rd_n;
    logic [CNT_W-1:0]  u_cnt, u_cnt_n;
    logic              busy1, busy2, issue;

    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
        return (c != '0) ? c - ONE_C : '0;
    endfunction

    // Branches read operands in ID, so they also wait out the final countdown step.
    always_comb begin
        busy1 = id_use_rs1 && (id_rs1 != '0) &&
                (id_branch ? (cnt[id_rs1] != '0) : (cnt[id_rs1] > ONE_C));
        busy2 = id_use_rs2 && (id_rs2 != '0) &&
                (id_branch ? (cnt[id_rs2] != '0) : (cnt[id_rs2] > ONE_C));
    end

    assign stall    = mem_wait | (id_valid & (busy1 | busy2));
    assign pc_write = ~stall;
    assign bubble   = stall & ~mem_wait;
    assign issue    = id_valid & ~stall & ~ex_kill & id_regwrite & (id_rd != '0);

    always_comb begin
        cnt_n   = cnt;
        u_vld_n = u_vld;
        u_rd_n  = u_rd;
        u_cnt_n = u_cnt;
        if (!mem_wait) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_n[r] = dec(cnt[r]);
            end
            // A squashed writer hands the register back to the older in-flight one.
            if (ex_kill && u_vld) begin
                cnt_n[u_rd] = dec(u_cnt);
            end
            u_vld_n = issue;
            if (issue) begin
                cnt_n[id_rd] = id_is_load ? LOAD_C : ALU_C;
                u_rd_n       = id_rd;
                u_cnt_n      = dec(cnt[id_rd]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            u_vld <= 1'b0;
            u_rd  <= '0;
            u_cnt <= '0;
        end else begin
            cnt   <= cnt_n;
            u_vld <= u_vld_n;
            u_rd  <= u_rd_n;
            u_cnt <= u_cnt_n;
        end
    end

`ifdef HZD_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hzd_scoreboard.sv
// Testbench for hzd_scoreboard: directed hazard scenarios plus randomized
// traffic checked against a ready-time model of the register file.
module tb_hzd_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid, id_use_rs1, id_use_rs2, id_branch;
    logic        id_regwrite, id_is_load, mem_wait, ex_kill;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        stall, pc_write, bubble;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: absolute time at which each register's value is forwardable.
    int now;
    int ready_at [32];
    bit u_v;
    int u_r;
    int u_prev;
    int m_perf;

    always #5 clk = ~clk;

    hzd_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_branch(id_branch), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_rd(id_rd),
        .mem_wait(mem_wait), .ex_kill(ex_kill),
        .stall(stall), .pc_write(pc_write), .bubble(bubble),
        .stall_cycles(stall_cycles)
    );

    function automatic int rem(input int r);
        return (ready_at[r] > now) ? ready_at[r] - now : 0;
    endfunction

    function automatic bit m_busy(input int r, input bit u, input bit br);
        if (!u || r == 0) return 1'b0;
        return br ? (rem(r) > 0) : (rem(r) > 1);
    endfunction

    function automatic bit m_stall();
        return mem_wait || (id_valid &&
               (m_busy(int'(id_rs1), id_use_rs1, id_branch) ||
                m_busy(int'(id_rs2), id_use_rs2, id_branch)));
    endfunction

    task automatic model_reset();
        now = 0;
        foreach (ready_at[i]) ready_at[i] = 0;
        u_v = 1'b0;
        u_r = 0;
        u_prev = 0;
        m_perf = 0;
    endtask

    task automatic model_edge();
        bit st;
        bit iss;
        st = m_stall();
        if (st) m_perf++;
        if (mem_wait) return;
        iss = id_valid && !st && !ex_kill && id_regwrite && id_rd != 0;
        if (ex_kill && u_v) ready_at[u_r] = u_prev;
        u_v = iss;
        if (iss) begin
            u_r = int'(id_rd);
            u_prev = ready_at[u_r];
            ready_at[u_r] = now + 1 + (id_is_load ? 2 : 1);
        end
        now++;
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2,
                         input bit u1, input bit u2, input bit br,
                         input bit rw, input bit ld, input int rd,
                         input bit mw, input bit kl);
        id_valid = v;
        id_rs1 = 5'(rs1);
        id_rs2 = 5'(rs2);
        id_use_rs1 = u1;
        id_use_rs2 = u2;
        id_branch = br;
        id_regwrite = rw;
        id_is_load = ld;
        id_rd = 5'(rd);
        mem_wait = mw;
        ex_kill = kl;
        #1;
    endtask

    task automatic tick();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({stall, pc_write, bubble} !== 3'b010 || stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async got s/p/b=%b cyc=%0d exp 010/0",
                     {stall, pc_write, bubble}, stall_cycles);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({stall, pc_write, bubble} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_held got %b exp 010", {stall, pc_write, bubble});
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({stall, pc_write, bubble} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_after got %b exp 010", {stall, pc_write, bubble});
        end
        tick();
    endtask

    task automatic test_alu_use();
        idle();
        drive(1, 1, 2, 1, 1, 0, 1, 0, 5, 0, 0);
        tick();
        drive(1, 5, 0, 1, 0, 0, 1, 0, 6, 0, 0);
        n_tests++;
        if ({stall, pc_write, bubble} !== 3'b010) begin
            n_fail++;
            $display("FAIL alu_use got %b exp 010", {stall, pc_write, bubble});
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        drive(1, 1, 0, 1, 0, 0, 1, 1, 5, 0, 0);
        tick();
        drive(1, 5, 2, 1, 1, 0, 1, 0, 6, 0, 0);
        n_tests++;
        if ({stall, pc_write, bubble} !== 3'b101) begin
            n_fail++;
            $display("FAIL load_use_c1 got %b exp 101", {stall, pc_write, bubble});
        end
        tick();
        n_tests++;
        if ({stall, pc_write, bubble} !== 3'b010) begin
            n_fail++;
            $display("FAIL load_use_c2 got %b exp 010", {stall, pc_write, bubble});
        end
        tick();
    endtask

    task automatic test_load_branch();
        idle();
        drive(1, 1, 0, 1, 0, 0, 1, 1, 5, 0, 0);
        tick();
        drive(1, 5, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (stall !== (c < 2)) begin
                n_fail++;
                $display("FAIL load_branch_c%0d got %b exp %b", c, stall, c < 2);
            end
            tick();
        end
    endtask

    task automatic test_alu_branch();
        idle();
        drive(1, 1, 2, 1, 1, 0, 1, 0, 7, 0, 0);
        tick();
        drive(1, 7, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if (stall !== (c < 1)) begin
                n_fail++;
                $display("FAIL alu_branch_c%0d got %b exp %b", c, stall, c < 1);
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        idle();
        drive(1, 1, 0, 1, 0, 0, 1, 1, 5, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1, 5, 0, 1, 0, 0, 1, 0, 6, 1, 0);
            n_tests++;
            if ({stall, pc_write, bubble} !== 3'b100) begin
                n_fail++;
                $display("FAIL mem_wait_c%0d got %b exp 100", c, {stall, pc_write, bubble});
            end
            tick();
        end
        drive(1, 5, 0, 1, 0, 0, 1, 0, 6, 0, 0);
        n_tests++;
        if ({stall, pc_write, bubble} !== 3'b101) begin
            n_fail++;
            $display("FAIL mem_wait_frozen got %b exp 101", {stall, pc_write, bubble});
        end
        tick();
        n_tests++;
        if ({stall, pc_write, bubble} !== 3'b010) begin
            n_fail++;
            $display("FAIL mem_wait_resolve got %b exp 010", {stall, pc_write, bubble});
        end
        tick();
    endtask

    task automatic test_kill();
        idle();
        drive(1, 1, 0, 1, 0, 0, 1, 1, 5, 0, 0);
        tick();
        drive(1, 1, 2, 1, 1, 0, 1, 0, 5, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 5, 0, 1, 0, 0, 1, 0, 6, 0, 0);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_load_use got %b exp 0", stall);
        end
        tick();
        // Older ALU writer, younger load squashed: x5 must become free at once.
        idle();
        drive(1, 1, 2, 1, 1, 0, 1, 0, 5, 0, 0);
        tick();
        drive(1, 1, 0, 1, 0, 0, 1, 1, 5, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 5, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_restore_branch got %b exp 0", stall);
        end
        tick();
    endtask

    task automatic test_x0();
        idle();
        drive(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_branch got %b exp 0", stall);
        end
        tick();
        drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_use got %b exp 0", stall);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        idle();
        drive(1, 1, 0, 1, 0, 0, 1, 1, 5, 0, 0);
        tick();
        drive(1, 5, 0, 1, 0, 0, 1, 0, 6, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({stall, pc_write, bubble} !== 3'b010) begin
            n_fail++;
            $display("FAIL mid_reset got %b exp 010", {stall, pc_write, bubble});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_perf();
        logic [31:0] exp;
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HZD_PERF_EN
        exp = 32'd4;
`else
        exp = 32'd0;
`endif
        n_tests++;
        if (stall_cycles !== exp) begin
            n_fail++;
            $display("FAIL perf_count got %0d exp %0d", stall_cycles, exp);
        end
        tick();
    endtask

    task automatic test_random();
        bit e;
        logic [31:0] ec;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            e = m_stall();
`ifdef HZD_PERF_EN
            ec = 32'(m_perf);
`else
            ec = 32'd0;
`endif
            n_tests++;
            if ({stall, pc_write, bubble} !== {e, ~e, e & ~mem_wait} ||
                stall_cycles !== ec) begin
                n_fail++;
                $display("FAIL random_%0d got s/p/b=%b cyc=%0d exp %b cyc=%0d",
                         i, {stall, pc_write, bubble}, stall_cycles,
                         {e, ~e, e & ~mem_wait}, ec);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_alu_use();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_mem_wait();
        test_kill();
        test_x0();
        test_mid_reset();
        test_perf();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
